// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus between the fetch unit (master) and memory (slave).
interface instr_fetch_unit_if;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] imem_rdata;
  logic        imem_ack;

  modport master (output imem_addr, output imem_req, input imem_rdata, input imem_ack);
  modport slave  (input imem_addr, input imem_req, output imem_rdata, output imem_ack);
endinterface

// File: rtl/instr_fetch_unit.sv
// PC register with branch/jump load plus a two-state instruction fetch FSM.
// Fetch latency is 2 cycles minimum; memory stalls up to 16 WAIT cycles before the fetch is abandoned.
module instr_fetch_unit (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                PCSrc,
  input  logic                      PCWrite,
  input  logic                      PCBEqCond,
  input  logic                      PCBNqCond,
  input  logic                      IRWrite,
  input  logic                      zero,
  input  logic [15:0]               alu_result,
  input  logic [15:0]               alu_out,
  instr_fetch_unit_if.master        mem,
  output logic [15:0]               pc,
  output logic [15:0]               ir,
  output logic [3:0]                opcode,
  output logic [3:0]                func_field,
  output logic                      ir_valid,
  output logic                      fetch_busy,
  output logic                      fetch_err
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [3:0]  tmo_cnt;
  logic        busy_q;
  logic [15:0] addr_q;
  logic        pc_load;
  logic [15:0] pc_next;

  always_comb begin
    pc_load = PCWrite | (PCBEqCond & zero) | (PCBNqCond & ~zero);
    pc_next = pc;
    if (pc_load) begin
      case (PCSrc)
        2'b00:   pc_next = alu_result;
        2'b01:   pc_next = {pc[15:12], ir[11:0]};
        2'b10:   pc_next = alu_out;
        default: pc_next = pc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= 16'h0000;
      addr_q    <= 16'h0000;
      ir        <= 16'h0000;
      ir_valid  <= 1'b0;
      busy_q    <= 1'b0;
      fetch_err <= 1'b0;
      tmo_cnt   <= 4'h0;
      state     <= IDLE;
    end else begin
      pc <= pc_next;
      case (state)
        IDLE: begin
          // Address comes from the pre-update pc; a same-cycle pc load lands afterwards.
          if (IRWrite) begin
            addr_q   <= pc;
            state    <= WAIT;
            busy_q   <= 1'b1;
            ir_valid <= 1'b0;
            tmo_cnt  <= 4'h0;
          end
        end
        WAIT: begin
          if (mem.imem_ack) begin
            ir       <= mem.imem_rdata;
            ir_valid <= 1'b1;
            state    <= IDLE;
            busy_q   <= 1'b0;
          end else if (tmo_cnt == 4'hF) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            fetch_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem.imem_addr = addr_q;
  assign mem.imem_req  = busy_q;
  assign fetch_busy    = busy_q;
  assign opcode        = ir[15:12];
  assign func_field    = ir[3:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: pc-source vector table plus hand-written fetch sequences.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  PCSrc;
  logic        PCWrite, PCBEqCond, PCBNqCond, IRWrite, zero;
  logic [15:0] alu_result, alu_out;
  logic [15:0] pc, ir;
  logic [3:0]  opcode, func_field;
  logic        ir_valid, fetch_busy, fetch_err;

  instr_fetch_unit_if mem_if ();

  instr_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .PCSrc      (PCSrc),
    .PCWrite    (PCWrite),
    .PCBEqCond  (PCBEqCond),
    .PCBNqCond  (PCBNqCond),
    .IRWrite    (IRWrite),
    .zero       (zero),
    .alu_result (alu_result),
    .alu_out    (alu_out),
    .mem        (mem_if),
    .pc         (pc),
    .ir         (ir),
    .opcode     (opcode),
    .func_field (func_field),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err)
  );

  typedef struct {
    logic [15:0] pc_init;
    logic [1:0]  src;
    logic        wr;
    logic        beq;
    logic        bne;
    logic        z;
    logic [15:0] ares;
    logic [15:0] aout;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs [10];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_ctrl();
    PCSrc = 2'b00; PCWrite = 1'b0; PCBEqCond = 1'b0; PCBNqCond = 1'b0;
    IRWrite = 1'b0; zero = 1'b0; alu_result = 16'h0; alu_out = 16'h0;
    mem_if.imem_ack = 1'b0;
  endtask

  task automatic set_pc(input logic [15:0] v);
    clear_ctrl();
    PCWrite = 1'b1; alu_result = v;
    step();
    clear_ctrl();
  endtask

  task automatic do_fetch(input logic [15:0] data);
    clear_ctrl();
    IRWrite = 1'b1;
    step();
    IRWrite = 1'b0;
    mem_if.imem_rdata = data; mem_if.imem_ack = 1'b1;
    step();
    mem_if.imem_ack = 1'b0;
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_pc"},        pc,               16'h0000);
    chk({pfx, "_addr"},      mem_if.imem_addr, 16'h0000);
    chk({pfx, "_ir"},        ir,               16'h0000);
    chk({pfx, "_ir_valid"},  {15'h0, ir_valid},   16'h0);
    chk({pfx, "_req"},       {15'h0, mem_if.imem_req}, 16'h0);
    chk({pfx, "_busy"},      {15'h0, fetch_busy}, 16'h0);
    chk({pfx, "_err"},       {15'h0, fetch_err},  16'h0);
  endtask

  initial begin
    // pc_init, src, wr, beq, bne, z, alu_result, alu_out, expected pc
    vecs[0] = '{16'hA000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h5678, 16'h1234};
    vecs[1] = '{16'hA000, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h5678, 16'hAABC};
    vecs[2] = '{16'hA000, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h5678, 16'h5678};
    vecs[3] = '{16'hA000, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h5678, 16'hA000};
    vecs[4] = '{16'h1000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0042, 16'h0000, 16'h0042};
    vecs[5] = '{16'h1000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0042, 16'h0000, 16'h1000};
    vecs[6] = '{16'h1000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0042, 16'h0000, 16'h0042};
    vecs[7] = '{16'h1000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0042, 16'h0000, 16'h1000};
    vecs[8] = '{16'hFFFF, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    vecs[9] = '{16'h2222, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7777, 16'h8888, 16'h2222};

    clear_ctrl();
    mem_if.imem_rdata = 16'h0;
    rst = 1'b1;
    step();
    step();
    chk_reset_state("reset");
    rst = 1'b0;

    // Zero-wait fetch
    set_pc(16'h0010);
    IRWrite = 1'b1;
    step();
    IRWrite = 1'b0;
    chk("zw_addr", mem_if.imem_addr, 16'h0010);
    chk("zw_req", {15'h0, mem_if.imem_req}, 16'h1);
    chk("zw_busy", {15'h0, fetch_busy}, 16'h1);
    mem_if.imem_rdata = 16'h8123; mem_if.imem_ack = 1'b1;
    step();
    mem_if.imem_ack = 1'b0;
    chk("zw_ir", ir, 16'h8123);
    chk("zw_opcode", {12'h0, opcode}, 16'h0008);
    chk("zw_func", {12'h0, func_field}, 16'h0003);
    chk("zw_ir_valid", {15'h0, ir_valid}, 16'h1);
    chk("zw_req_low", {15'h0, mem_if.imem_req}, 16'h0);

    // PC source / branch table, with ir = 0x3ABC
    do_fetch(16'h3ABC);
    chk("tbl_ir", ir, 16'h3ABC);
    for (int i = 0; i < 10; i++) begin
      set_pc(vecs[i].pc_init);
      PCSrc = vecs[i].src; PCWrite = vecs[i].wr; PCBEqCond = vecs[i].beq;
      PCBNqCond = vecs[i].bne; zero = vecs[i].z;
      alu_result = vecs[i].ares; alu_out = vecs[i].aout;
      step();
      clear_ctrl();
      chk($sformatf("pcvec%0d", i), pc, vecs[i].exp_pc);
    end

    // IRWrite colliding with a pc load; second IRWrite and pc load during WAIT
    set_pc(16'h0004);
    IRWrite = 1'b1; PCWrite = 1'b1; alu_result = 16'h0005;
    step();
    chk("col_addr", mem_if.imem_addr, 16'h0004);
    chk("col_pc", pc, 16'h0005);
    chk("col_ir_valid_clr", {15'h0, ir_valid}, 16'h0);
    alu_result = 16'h0099;
    step();
    chk("col_wait_addr", mem_if.imem_addr, 16'h0004);
    chk("col_wait_pc", pc, 16'h0099);
    chk("col_wait_req", {15'h0, mem_if.imem_req}, 16'h1);
    clear_ctrl();
    mem_if.imem_rdata = 16'h1111; mem_if.imem_ack = 1'b1;
    step();
    mem_if.imem_ack = 1'b0;
    chk("col_ir", ir, 16'h1111);
    step();
    chk("col_no_queue_req", {15'h0, mem_if.imem_req}, 16'h0);
    mem_if.imem_rdata = 16'h2222; mem_if.imem_ack = 1'b1;
    step();
    mem_if.imem_ack = 1'b0;
    chk("idle_ack_ir", ir, 16'h1111);
    chk("idle_ack_valid", {15'h0, ir_valid}, 16'h1);

    // Ack on the 16th WAIT cycle wins over the timeout
    set_pc(16'h0200);
    IRWrite = 1'b1;
    step();
    IRWrite = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("ack16_req_still", {15'h0, mem_if.imem_req}, 16'h1);
    mem_if.imem_rdata = 16'h5A5A; mem_if.imem_ack = 1'b1;
    step();
    mem_if.imem_ack = 1'b0;
    chk("ack16_ir", ir, 16'h5A5A);
    chk("ack16_valid", {15'h0, ir_valid}, 16'h1);
    chk("ack16_err", {15'h0, fetch_err}, 16'h0);
    chk("ack16_req", {15'h0, mem_if.imem_req}, 16'h0);

    // Timeout after 16 WAIT cycles without ack
    IRWrite = 1'b1;
    step();
    IRWrite = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("tmo_req_c16", {15'h0, mem_if.imem_req}, 16'h1);
    chk("tmo_err_c16", {15'h0, fetch_err}, 16'h0);
    step();
    chk("tmo_err", {15'h0, fetch_err}, 16'h1);
    chk("tmo_req", {15'h0, mem_if.imem_req}, 16'h0);
    chk("tmo_valid", {15'h0, ir_valid}, 16'h0);
    chk("tmo_ir", ir, 16'h5A5A);
    step();
    chk("tmo_err_sticky", {15'h0, fetch_err}, 16'h1);

    // Reset on WAIT cycle 3 with a simultaneous ack
    set_pc(16'h0300);
    IRWrite = 1'b1;
    step();
    IRWrite = 1'b0;
    step();
    step();
    rst = 1'b1;
    mem_if.imem_rdata = 16'hBEEF; mem_if.imem_ack = 1'b1;
    step();
    rst = 1'b0;
    mem_if.imem_ack = 1'b0;
    chk_reset_state("midrst");
    step();
    chk_reset_state("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk in 1 (all state on rising edge); rst in 1 (synchronous, active-high).
REQ-002 Control inputs SHALL be: PCSrc in 2 (next-PC select); PCWrite in 1 (unconditional PC load); PCBEqCond in 1 (load if zero); PCBNqCond in 1 (load if !zero); IRWrite in 1 (fetch-start strobe); zero in 1 (ALU zero flag).
REQ-003 Data inputs SHALL be: alu_result in 16 (combinational ALU output); alu_out in 16 (registered ALU result); imem_rdata in 16 (fetched word); imem_ack in 1 (memory data-valid).
REQ-004 Outputs SHALL be: pc out 16; imem_addr out 16; imem_req out 1; ir out 16; opcode out 4 (= ir[15:12]); func_field out 4 (= ir[3:0]); ir_valid out 1; fetch_busy out 1; fetch_err out 1.

Function
REQ-005 pc_load SHALL equal PCWrite | (PCBEqCond & zero) | (PCBNqCond & !zero).
REQ-006 When pc_load=1, pc SHALL take, by PCSrc: 00 alu_result; 01 {pc[15:12], ir[11:0]}; 10 alu_out; 11 pc unchanged.
REQ-007 When pc_load=0, pc SHALL hold; pc arithmetic is 16-bit wrap-around, with no carry out.
REQ-008 The fetch FSM SHALL have two states: IDLE and WAIT.
REQ-009 In IDLE, IRWrite=1 SHALL latch the pre-update pc into imem_addr and enter WAIT; the same-cycle pc_load still updates pc.
REQ-010 imem_req and fetch_busy SHALL be 1 exactly while in WAIT, driven from registers with no combinational path from inputs.
REQ-011 imem_addr SHALL remain stable throughout WAIT.
REQ-012 In WAIT, imem_ack=1 SHALL capture imem_rdata into ir, set ir_valid=1 and return to IDLE; imem_req=0 from the next cycle.
REQ-013 Minimum latency SHALL be: IRWrite at cycle N, imem_req high at N+1, ack at N+1, ir/ir_valid updated and visible at N+2.
REQ-014 ir_valid SHALL clear to 0 on the cycle WAIT is entered and stay 0 until a successful capture.
REQ-015 A 4-bit timeout counter SHALL clear on WAIT entry and increment on each WAIT cycle without ack.
REQ-016 On the 16th consecutive WAIT cycle without ack, the FSM SHALL return to IDLE, set fetch_err=1 (sticky until rst), and leave ir unchanged with ir_valid=0.
REQ-017 If ack arrives on the 16th WAIT cycle, ack SHALL win: capture occurs and fetch_err is unchanged.
REQ-018 IRWrite asserted while in WAIT SHALL be ignored; it is not queued.
REQ-019 imem_ack while in IDLE SHALL be ignored; ir and ir_valid are unchanged.
REQ-020 opcode and func_field SHALL be pure combinational slices of ir.
REQ-021 pc updates during WAIT SHALL NOT alter imem_addr or the fetch in progress.

Reset
REQ-022 With rst=1 at a clock edge, the block SHALL set pc=0, imem_addr=0, ir=0, ir_valid=0, imem_req=0, fetch_busy=0, fetch_err=0, timeout counter=0 and state=IDLE.
REQ-023 rst SHALL take priority over every other input, including in mid-WAIT; an ack in the reset cycle is discarded.
REQ-024 Outputs SHALL hold their reset values until the first edge after rst deasserts.

Verification
REQ-025 Zero-wait fetch: pc=0x0010, IRWrite=1 at N, imem_rdata=0x8123, ack at N+1 -> imem_addr=0x0010 and req=1 at N+1; ir=0x8123, opcode=0x8, func_field=0x3, ir_valid=1, req=0 at N+2.
REQ-026 PC sources: PCWrite=1 with PCSrc=00/01/10/11, alu_result=0x1234, alu_out=0x5678, pc=0xA000, ir=0x3ABC -> pc=0x1234, 0xAABC, 0x5678, 0xA000 (unchanged) respectively.
REQ-027 Branches: PCBEqCond=1 with zero=1 -> pc loads; with zero=0 -> pc holds; PCBNqCond=1 gives the inverse; pc=0xFFFF with alu_result=0x0000 -> 0x0000.
REQ-028 Timeout: IRWrite with no ack for 16 WAIT cycles -> fetch_err=1, req=0, ir_valid=0, ir unchanged; ack on the 16th cycle instead -> capture occurs and fetch_err stays 0.
REQ-029 Collisions: IRWrite with PCWrite in the same cycle (pc 0x0004 -> 0x0005) -> imem_addr=0x0004; second IRWrite in WAIT -> no effect; ack in IDLE -> no effect.
REQ-030 Reset mid-WAIT: rst=1 on cycle 3 of WAIT with ack=1 -> all outputs at REQ-022 values and ir=0.
